// File: rtl/decode_38_pkg.sv
// Shared widths and the 3-to-8 decode function for decode_38.
package decode_38_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;

  // Active-high one-hot decode of a select value.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
    return OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/decode_38_sync.sv
// N-stage, W-bit synchronizer with async active-low clear.
// Ports:
//   clk   rising-edge clock
//   rst_n async active-low clear of every stage
//   d     asynchronous input bus
//   q     synchronized output (d itself when N == 0)
module decode_38_sync #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (N == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [W-1:0] stage [N];

      // All bits move through one chain so they are sampled on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(N); i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < int'(N); i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[N-1];
    end
  endgenerate

endmodule

// File: rtl/decode_38.sv
// 3-to-8 decoder with synchronized inputs and a registered one-hot
// (or one-cold) output for indicator lines.
// Ports:
//   clk    rising-edge clock
//   rst_n  async active-low reset; forces code inactive
//   en     decode enable (asynchronous source)
//   sw     3-bit select (asynchronous source)
//   code   registered decode; bit sw active while en, else all inactive
module decode_38
  import decode_38_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sw,
  output logic [OUT_W-1:0] code
);

  localparam logic [OUT_W-1:0] CODE_IDLE = {OUT_W{OUT_ACTIVE_LOW}};

  logic             en_s;
  logic [SEL_W-1:0] sw_s;
  logic [OUT_W-1:0] code_next_c;

  // Enable and select share one chain so they can never be skewed.
  decode_38_sync #(
    .N (SYNC_STAGES),
    .W (SEL_W + 1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({en, sw}),
    .q     ({en_s, sw_s})
  );

  // Decode, with enable taking priority, then apply output polarity.
  always_comb begin
    code_next_c = '0;
    if (en_s) code_next_c = onehot(sw_s);
    code_next_c = code_next_c ^ CODE_IDLE;
  end

  // Output register: code is driven straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code <= CODE_IDLE;
    else        code <= code_next_c;
  end

endmodule

// File: tb/tb_decode_38.sv
module tb_decode_38;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [2:0] sw = 3'd0;
  logic [7:0] code;
  logic       en2 = 1'b0;
  logic [2:0] sw2 = 3'd0;
  logic [7:0] code2;

  int total = 0;
  int passed = 0;

  logic [7:0] sweep_exp [8];
  logic [2:0] hist [64];

  always #5 clk = ~clk;

  decode_38 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sw    (sw),
    .code  (code)
  );

  decode_38 #(
    .SYNC_STAGES    (0),
    .OUT_ACTIVE_LOW (1'b1)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en2),
    .sw    (sw2),
    .code  (code2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Reset held with live inputs
    #2;
    sw = 3'd5; en = 1'b1;
    rst_n = 1'b0;
    tick(2);
    check("reset_hold", code, 8'h00);
    check("reset_hold_al", code2, 8'hFF);
    rst_n = 1'b1;
    tick(2);
    check("release_2edges", code, 8'h00);
    tick(1);
    check("release_3edges", code, 8'h20);

    // Sweep 0..7 on consecutive cycles, 3-cycle latency
    for (int i = 0; i < 11; i++) begin
      if (i >= 3) check($sformatf("sweep_%0d", i - 3), code, sweep_exp[i-3]);
      if (i < 8) sw = 3'(i);
      tick(1);
    end

    // Long incrementing run with wrap 7->0
    for (int i = 0; i < 53; i++) begin
      if (i >= 3) begin
        check($sformatf("run_%0d", i - 3), code, 8'h01 << hist[i-3]);
        check($sformatf("run_ones_%0d", i - 3), 8'($countones(code)), 8'd1);
      end
      if (i < 50) begin
        hist[i] = 3'(i);
        sw = 3'(i);
      end
      tick(1);
    end

    // Enable control
    en = 1'b0; sw = 3'd3;
    tick(3);
    check("en_low", code, 8'h00);
    en = 1'b1;
    tick(2);
    check("en_rise_2", code, 8'h00);
    tick(1);
    check("en_rise_3", code, 8'h08);
    en = 1'b0;
    tick(2);
    check("en_fall_2", code, 8'h08);
    tick(1);
    check("en_fall_3", code, 8'h00);

    // Enable rising together with a select change decodes the new select
    en = 1'b1; sw = 3'd1;
    tick(3);
    check("en_rise_sw_chg", code, 8'h02);
    // Enable falling together with a select change gives inactive output
    en = 1'b0; sw = 3'd4;
    tick(3);
    check("en_fall_sw_chg", code, 8'h00);

    // Asynchronous reset between edges
    en = 1'b1; sw = 3'd6;
    tick(3);
    check("pre_async", code, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", code, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("no_stale_1", code, 8'h00);
    tick(1);
    check("no_stale_2", code, 8'h00);
    tick(1);
    check("after_rst_3", code, 8'h40);

    // Bypass synchronizer, active-low output
    sw2 = 3'd2; en2 = 1'b1;
    tick(1);
    check("al_sw2", code2, 8'hFB);
    sw2 = 3'd7;
    tick(1);
    check("al_sw7", code2, 8'h7F);
    sw2 = 3'd0;
    tick(1);
    check("al_sw0", code2, 8'hFE);
    en2 = 1'b0;
    tick(1);
    check("al_en0", code2, 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
